// File: rtl/mvau_weight_streamer.sv
// rtl/mvau_weight_streamer.sv - streams weight words from a weight memory to an MVAU compute stage
//
// Purpose: on start, reads the weight memory 0..WMEM_DEPTH-1 num_reps times and
// forwards each word on an AXI-Stream-like master port through a 4-entry output
// FIFO. The memory has one cycle of read latency. Reads are only issued when the
// FIFO has room for them.
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   start, num_reps     job start pulse and pass count (sampled with start)
//   busy, done          job in progress, one-cycle end-of-job pulse
//   wmem_addr, wmem_out weight memory read address / read data
//   m_axis_tdata/tvalid/tready  weight word stream to the compute stage
//   m_axis_tlast        last word of each pass (only with MVAU_WSTRM_TLAST_EN)
//
// Optional feature macro: MVAU_WSTRM_TLAST_EN
module mvau_weight_streamer #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [15:0]             num_reps,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  output logic [SIMD*TW-1:0]      m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef MVAU_WSTRM_TLAST_EN
  ,
  output logic                    m_axis_tlast
`endif
);
  localparam int DW = SIMD * TW;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_ONE  = WMEM_ADDR_BW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [15:0]             reps_q;
  logic [15:0]             rep_cnt;
  // rd_v1: a read address is on wmem_addr this cycle; rd_v2: its data is on wmem_out
  logic                    rd_v1;
  logic                    rd_v2;
  logic [DW-1:0]           fifo_data [4];
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              fifo_cnt;

  logic                    issue_first;
  logic                    issue_next;
  logic                    zero_job;
  logic                    job_end;
  logic [2:0]              committed;
  logic                    room;
  logic                    last_issued;
  logic                    push;
  logic                    pop;
  logic [WMEM_ADDR_BW-1:0] issue_addr;

  assign push          = rd_v2;
  assign m_axis_tvalid = (fifo_cnt != 3'd0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign busy          = (state != IDLE);
  // Words already buffered plus reads still in the memory pipeline: never let
  // this exceed the FIFO size, otherwise a returning word would have nowhere to go.
  assign committed     = fifo_cnt + {2'b00, rd_v1} + {2'b00, rd_v2};
  assign room          = (committed < 3'd4);
  assign last_issued   = (wmem_addr == LAST_ADDR) && (rep_cnt == reps_q - 16'd1);
  // Final word leaves the FIFO with nothing else buffered or in flight.
  assign job_end       = (state == DRAIN) && pop && (fifo_cnt == 3'd1) && !rd_v1 && !rd_v2;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_first = 1'b0;
    issue_next  = 1'b0;
    zero_job    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_reps != 16'd0) begin
            state_nxt   = STREAM;
            issue_first = 1'b1;
          end else begin
            zero_job = 1'b1;
          end
        end
      end
      STREAM: begin
        if (last_issued)  state_nxt  = DRAIN;
        else if (room)    issue_next = 1'b1;
      end
      DRAIN: begin
        if (job_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_addr = '0;
    if (issue_next && (wmem_addr != LAST_ADDR)) issue_addr = wmem_addr + ADDR_ONE;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wmem_addr <= '0;
      reps_q    <= '0;
      rep_cnt   <= '0;
      rd_v1     <= 1'b0;
      rd_v2     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done  <= zero_job || job_end;
      rd_v1 <= issue_first || issue_next;
      rd_v2 <= rd_v1;
      if (issue_first) begin
        wmem_addr <= '0;
        rep_cnt   <= '0;
        reps_q    <= num_reps;
      end else if (issue_next) begin
        wmem_addr <= issue_addr;
        if (wmem_addr == LAST_ADDR) rep_cnt <= rep_cnt + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_data[wr_ptr] <= wmem_out;
  end

`ifdef MVAU_WSTRM_TLAST_EN
  logic       last_v1;
  logic       last_v2;
  logic [3:0] fifo_last;

  // The last-of-pass flag rides alongside the read pipeline and FIFO entry.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_v1   <= 1'b0;
      last_v2   <= 1'b0;
      fifo_last <= '0;
    end else begin
      last_v1 <= (issue_first || issue_next) && (issue_addr == LAST_ADDR);
      last_v2 <= last_v1;
      if (push) fifo_last[wr_ptr] <= last_v2;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && fifo_last[rd_ptr];
`endif

endmodule
